// File: rtl/clock_pkg.sv
// Shared types, field limits and wrap-around step helpers for the clock
// time-setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        SET_HOURS   = 2'd1,
        SET_MINUTES = 2'd2,
        SET_SECONDS = 2'd3
    } ctl_state_t;

    localparam int HOURS_W   = 5;
    localparam int MIN_SEC_W = 6;

    localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
    localparam logic [MIN_SEC_W-1:0] MIN_SEC_MAX = 6'd59;

    // Field-width arithmetic with compare-and-wrap; out-of-range inputs
    // collapse to 0 on increment so an edit value can never escape its range.
    function automatic logic [HOURS_W-1:0] step_hours(
        input logic [HOURS_W-1:0] val,
        input logic               up
    );
        if (up) begin
            return (val >= HOURS_MAX) ? '0 : val + HOURS_W'(1);
        end
        return (val == '0) ? HOURS_MAX : val - HOURS_W'(1);
    endfunction

    function automatic logic [MIN_SEC_W-1:0] step_min_sec(
        input logic [MIN_SEC_W-1:0] val,
        input logic                 up
    );
        if (up) begin
            return (val >= MIN_SEC_MAX) ? '0 : val + MIN_SEC_W'(1);
        end
        return (val == '0) ? MIN_SEC_MAX : val - MIN_SEC_W'(1);
    endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Front-panel buttons plus the time counter's status/enable/parallel-load port.
// master: panel and counter side; slave: the set controller.
interface clock_set_if;
    import clock_pkg::*;

    logic                 btn_mode;
    logic                 btn_inc;
    logic                 btn_dec;
    logic [HOURS_W-1:0]   cur_hours;
    logic [MIN_SEC_W-1:0] cur_minutes;
    logic [MIN_SEC_W-1:0] cur_seconds;
    logic                 count_en;
    logic                 load_en;
    logic [HOURS_W-1:0]   load_hours;
    logic [MIN_SEC_W-1:0] load_minutes;
    logic [MIN_SEC_W-1:0] load_seconds;
    logic [1:0]           mode;
    logic                 blink;

    modport master (
        output btn_mode, btn_inc, btn_dec,
        output cur_hours, cur_minutes, cur_seconds,
        input  count_en, load_en, load_hours, load_minutes, load_seconds,
        input  mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec,
        input  cur_hours, cur_minutes, cur_seconds,
        output count_en, load_en, load_hours, load_minutes, load_seconds,
        output mode, blink
    );

endinterface

// File: rtl/clock_set_controller_btn_repeat.sv
// Press-edge detector with hold-to-repeat: one step on the press edge, one after
// REPEAT_DELAY held cycles, then one every REPEAT_RATE cycles while still held.
module btn_repeat #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic btn_i,
    input  logic clr_i,
    output logic edge_o,
    output logic step_o
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

    logic             btn_q;
    logic             rep_q, rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_d;

    assign edge_o = btn_i & ~btn_q;
    assign step_o = step_d;

    // cnt_q holds the number of cycles since the press edge (or since the
    // last repeat step), so a step fires on the cycle it equals the period.
    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves one unassigned infers a latch.
    always_comb begin
        cnt_d  = '0;
        rep_d  = 1'b0;
        step_d = 1'b0;
        if (btn_i && !clr_i) begin
            if (edge_o) begin
                step_d = 1'b1;
                cnt_d  = CNT_W'(1);
            end else if (!rep_q) begin
                if (cnt_q >= DELAY_C) begin
                    step_d = 1'b1;
                    rep_d  = 1'b1;
                    cnt_d  = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                rep_d = 1'b1;
                if (cnt_q >= RATE_C) begin
                    step_d = 1'b1;
                    cnt_d  = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= 1'b0;
            rep_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            btn_q <= btn_i;
            rep_q <= rep_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting controller: freezes the time-of-day counter while the user edits
// hours/minutes/seconds and parallel-loads the edited time on commit.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_RATE   = 10_000_000,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        tick_1hz,
    clock_set_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

    ctl_state_t           state_q, state_d;
    logic [HOURS_W-1:0]   edit_h_q, edit_h_d;
    logic [MIN_SEC_W-1:0] edit_m_q, edit_m_d;
    logic [MIN_SEC_W-1:0] edit_s_q, edit_s_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 blink_q, blink_d;
    logic                 hold_q, hold_d;
    logic                 load_en_q, load_en_d;
    logic                 mode_btn_q;

    logic mode_edge, in_set, rep_clr;
    logic inc_edge, inc_step, dec_edge, dec_step;
    logic step_any, activity;

    assign mode_edge = bus.btn_mode & ~mode_btn_q;
    assign in_set    = (state_q != RUN);
    // Repeat logic idles outside edit mode and while both buttons are down.
    assign rep_clr   = ~in_set | (bus.btn_inc & bus.btn_dec);

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_inc (
        .Clk     (Clk),
        .reset_n (reset_n),
        .btn_i   (bus.btn_inc),
        .clr_i   (rep_clr),
        .edge_o  (inc_edge),
        .step_o  (inc_step)
    );

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_dec (
        .Clk     (Clk),
        .reset_n (reset_n),
        .btn_i   (bus.btn_dec),
        .clr_i   (rep_clr),
        .edge_o  (dec_edge),
        .step_o  (dec_step)
    );

    // A mode edge takes precedence; a step arriving with it is dropped.
    assign step_any = (inc_step | dec_step) & ~mode_edge;
    assign activity = mode_edge | inc_edge | dec_edge | inc_step | dec_step;

    always_comb begin
        state_d   = state_q;
        edit_h_d  = edit_h_q;
        edit_m_d  = edit_m_q;
        edit_s_d  = edit_s_q;
        tmo_d     = tmo_q;
        blink_d   = blink_q;
        hold_d    = hold_q;
        load_en_d = 1'b0;

        unique case (state_q)
            RUN: begin
                tmo_d   = '0;
                blink_d = 1'b0;
                hold_d  = 1'b0;
                if (mode_edge) begin
                    state_d  = SET_HOURS;
                    edit_h_d = bus.cur_hours;
                    edit_m_d = bus.cur_minutes;
                    edit_s_d = bus.cur_seconds;
                    blink_d  = 1'b1;
                end
            end

            default: begin
                if (mode_edge) begin
                    tmo_d   = '0;
                    hold_d  = 1'b0;
                    blink_d = 1'b1;
                    unique case (state_q)
                        SET_HOURS:   state_d = SET_MINUTES;
                        SET_MINUTES: state_d = SET_SECONDS;
                        default: begin
                            state_d   = RUN;
                            load_en_d = 1'b1;
                            blink_d   = 1'b0;
                        end
                    endcase
                end else if (tick_1hz && !activity && tmo_q >= TMO_LAST) begin
                    // Abandon the edit: counter resumes from its frozen value.
                    state_d = RUN;
                    tmo_d   = '0;
                    blink_d = 1'b0;
                    hold_d  = 1'b0;
                end else begin
                    if (activity) begin
                        tmo_d = '0;
                    end else if (tick_1hz) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end

                    if (step_any) begin
                        unique case (state_q)
                            SET_HOURS:   edit_h_d = step_hours(edit_h_q, inc_step);
                            SET_MINUTES: edit_m_d = step_min_sec(edit_m_q, inc_step);
                            default:     edit_s_d = step_min_sec(edit_s_q, inc_step);
                        endcase
                        blink_d = 1'b1;
                        hold_d  = 1'b1;
                    end else if (tick_1hz) begin
                        // After a step, keep the field lit through the next tick.
                        if (hold_q) begin
                            hold_d = 1'b0;
                        end else begin
                            blink_d = ~blink_q;
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: edit registers are ordinary flops, not a memory, so they reset
    // with the rest of the state and load_* read 0 out of reset.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            edit_h_q   <= '0;
            edit_m_q   <= '0;
            edit_s_q   <= '0;
            tmo_q      <= '0;
            blink_q    <= 1'b0;
            hold_q     <= 1'b0;
            load_en_q  <= 1'b0;
            mode_btn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edit_h_q   <= edit_h_d;
            edit_m_q   <= edit_m_d;
            edit_s_q   <= edit_s_d;
            tmo_q      <= tmo_d;
            blink_q    <= blink_d;
            hold_q     <= hold_d;
            load_en_q  <= load_en_d;
            mode_btn_q <= bus.btn_mode;
        end
    end

    // count_en is decoded from the state register so it also covers the
    // commit cycle, where the counter prioritises the load.
    assign bus.count_en     = (state_q == RUN);
    assign bus.load_en      = load_en_q;
    assign bus.load_hours   = edit_h_q;
    assign bus.load_minutes = edit_m_q;
    assign bus.load_seconds = edit_s_q;
    assign bus.mode         = state_q;
    assign bus.blink        = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: scenario tasks plus a load
// scoreboard that pairs each expected commit with the DUT's load_en pulse.
module tb_clock_set_controller;

    localparam int DLY = 8;
    localparam int RATE = 4;
    localparam int TMO = 5;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } hms_t;

    logic Clk;
    logic reset_n;
    logic tick_1hz;

    clock_set_if bus();

    clock_set_controller #(
        .REPEAT_DELAY  (DLY),
        .REPEAT_RATE   (RATE),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .tick_1hz (tick_1hz),
        .bus      (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   loads_seen = 0;
    int   loads_pushed = 0;
    hms_t exp_q[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard side: every load_en pulse must match the oldest pending commit.
    always @(negedge Clk) begin
        if (reset_n === 1'b1 && bus.load_en === 1'b1) begin
            hms_t got;
            hms_t want;
            got = {bus.load_hours, bus.load_minutes, bus.load_seconds};
            loads_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: load_en=1 with %0d:%0d:%0d, required no load",
                         got.h, got.m, got.s);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL load_value: got %0d:%0d:%0d, expected %0d:%0d:%0d",
                             got.h, got.m, got.s, want.h, want.m, want.s);
                end
                checks++;
                if (bus.count_en !== 1'b1) begin
                    errors++;
                    $display("FAIL load_count_en: got %b, expected 1", bus.count_en);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hours   = 5'(h);
        bus.cur_minutes = 6'(m);
        bus.cur_seconds = 6'(s);
    endtask

    task automatic drive_btn(input int which, input logic val);
        case (which)
            0:       bus.btn_mode = val;
            1:       bus.btn_inc  = val;
            default: bus.btn_dec  = val;
        endcase
    endtask

    // which: 0 = mode, 1 = inc, 2 = dec
    task automatic press(input int which);
        @(negedge Clk);
        drive_btn(which, 1'b1);
        @(negedge Clk);
        drive_btn(which, 1'b0);
        @(negedge Clk);
    endtask

    task automatic pulse_tick();
        @(negedge Clk);
        tick_1hz = 1'b1;
        @(negedge Clk);
        tick_1hz = 1'b0;
    endtask

    task automatic push_load(input int h, input int m, input int s);
        hms_t e;
        e.h = 5'(h);
        e.m = 6'(m);
        e.s = 6'(s);
        exp_q.push_back(e);
        loads_pushed++;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        set_cur(12, 34, 56);
        repeat (3) @(negedge Clk);
        checks++; if (bus.count_en !== 1'b1)  begin errors++; $display("FAIL reset_count_en: got %b, expected 1", bus.count_en); end
        checks++; if (bus.load_en !== 1'b0)   begin errors++; $display("FAIL reset_load_en: got %b, expected 0", bus.load_en); end
        checks++; if (bus.mode !== 2'd0)      begin errors++; $display("FAIL reset_mode: got %0d, expected 0", bus.mode); end
        checks++; if (bus.blink !== 1'b0)     begin errors++; $display("FAIL reset_blink: got %b, expected 0", bus.blink); end
        checks++;
        if ({bus.load_hours, bus.load_minutes, bus.load_seconds} !== 17'd0) begin
            errors++;
            $display("FAIL reset_load_vals: got %0d:%0d:%0d, expected 0:0:0",
                     bus.load_hours, bus.load_minutes, bus.load_seconds);
        end
        reset_n = 1'b1;
        @(negedge Clk);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL post_reset_mode: got %0d, expected 0", bus.mode); end
    endtask

    task automatic test_enter_and_wrap();
        int exp_h;
        press(0);
        checks++; if (bus.mode !== 2'd1)     begin errors++; $display("FAIL enter_mode: got %0d, expected 1", bus.mode); end
        checks++; if (bus.count_en !== 1'b0) begin errors++; $display("FAIL enter_count_en: got %b, expected 0", bus.count_en); end
        checks++;
        if (bus.load_hours !== 5'd12 || bus.load_minutes !== 6'd34 || bus.load_seconds !== 6'd56) begin
            errors++;
            $display("FAIL enter_capture: got %0d:%0d:%0d, expected 12:34:56",
                     bus.load_hours, bus.load_minutes, bus.load_seconds);
        end
        exp_h = 12;
        for (int i = 0; i < 12; i++) begin
            press(1);
            exp_h = (exp_h + 1) % 24;
        end
        checks++; if (bus.load_hours !== 5'(exp_h)) begin errors++; $display("FAIL hours_wrap: got %0d, expected %0d", bus.load_hours, exp_h); end
        press(0);
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL to_minutes: got %0d, expected 2", bus.mode); end
        press(0);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL to_seconds: got %0d, expected 3", bus.mode); end
        push_load(exp_h, 34, 56);
        press(0);
        checks++; if (bus.mode !== 2'd0)     begin errors++; $display("FAIL commit_mode: got %0d, expected 0", bus.mode); end
        checks++; if (bus.count_en !== 1'b1) begin errors++; $display("FAIL commit_count_en: got %b, expected 1", bus.count_en); end
        checks++; if (loads_seen !== 1)      begin errors++; $display("FAIL commit_pulses: got %0d loads, expected 1", loads_seen); end
    endtask

    task automatic test_minutes_repeat();
        int exp_m;
        int n_steps;
        int hold;
        set_cur(12, 0, 56);
        press(0);
        press(0);
        checks++; if (bus.load_minutes !== 6'd0) begin errors++; $display("FAIL min_capture: got %0d, expected 0", bus.load_minutes); end
        press(2);
        exp_m = 59;
        checks++; if (bus.load_minutes !== 6'(exp_m)) begin errors++; $display("FAIL min_dec_wrap: got %0d, expected %0d", bus.load_minutes, exp_m); end
        hold = DLY + 3 * RATE;
        n_steps = 1;
        for (int k = DLY; k < hold; k += RATE) n_steps++;
        for (int i = 0; i < n_steps; i++) exp_m = (exp_m + 1) % 60;
        @(negedge Clk);
        bus.btn_inc = 1'b1;
        repeat (hold) @(negedge Clk);
        bus.btn_inc = 1'b0;
        @(negedge Clk);
        checks++; if (bus.load_minutes !== 6'(exp_m)) begin errors++; $display("FAIL min_repeat: got %0d, expected %0d (%0d steps)", bus.load_minutes, exp_m, n_steps); end
        press(0);
        push_load(12, exp_m, 56);
        press(0);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL repeat_commit_mode: got %0d, expected 0", bus.mode); end
    endtask

    task automatic test_simultaneous();
        press(0);
        @(negedge Clk);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        @(negedge Clk);
        checks++; if (bus.mode !== 2'd2)        begin errors++; $display("FAIL mode_wins_mode: got %0d, expected 2", bus.mode); end
        checks++; if (bus.load_hours !== 5'd12) begin errors++; $display("FAIL mode_wins_hours: got %0d, expected 12", bus.load_hours); end
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        @(negedge Clk);
        bus.btn_inc = 1'b1;
        bus.btn_dec = 1'b1;
        repeat (DLY + 2 * RATE) @(negedge Clk);
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        @(negedge Clk);
        checks++; if (bus.load_minutes !== 6'd0) begin errors++; $display("FAIL inc_dec_both: got %0d, expected 0", bus.load_minutes); end
        press(0);
        push_load(12, 0, 56);
        press(0);
    endtask

    task automatic test_timeout();
        int seen_before;
        seen_before = loads_seen;
        press(0);
        for (int i = 0; i < TMO - 1; i++) pulse_tick();
        @(negedge Clk);
        checks++; if (bus.mode !== 2'd1)     begin errors++; $display("FAIL tmo_early_mode: got %0d, expected 1", bus.mode); end
        checks++; if (bus.count_en !== 1'b0) begin errors++; $display("FAIL tmo_early_count_en: got %b, expected 0", bus.count_en); end
        pulse_tick();
        @(negedge Clk);
        checks++; if (bus.mode !== 2'd0)      begin errors++; $display("FAIL tmo_mode: got %0d, expected 0", bus.mode); end
        checks++; if (bus.count_en !== 1'b1)  begin errors++; $display("FAIL tmo_count_en: got %b, expected 1", bus.count_en); end
        checks++; if (bus.blink !== 1'b0)     begin errors++; $display("FAIL tmo_blink: got %b, expected 0", bus.blink); end
        checks++; if (loads_seen !== seen_before) begin errors++; $display("FAIL tmo_no_load: got %0d loads, expected %0d", loads_seen, seen_before); end
    endtask

    task automatic test_reset_mid_edit();
        press(0);
        press(0);
        press(0);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL mid_edit_mode: got %0d, expected 3", bus.mode); end
        @(negedge Clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.mode !== 2'd0)     begin errors++; $display("FAIL async_reset_mode: got %0d, expected 0", bus.mode); end
        checks++; if (bus.count_en !== 1'b1) begin errors++; $display("FAIL async_reset_count_en: got %b, expected 1", bus.count_en); end
        checks++; if (bus.load_en !== 1'b0)  begin errors++; $display("FAIL async_reset_load_en: got %b, expected 0", bus.load_en); end
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL after_reset_mode: got %0d, expected 0", bus.mode); end
    endtask

    initial begin
        test_reset();
        test_enter_and_wrap();
        test_minutes_repeat();
        test_simultaneous();
        test_timeout();
        test_reset_mid_edit();
        repeat (2) @(negedge Clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pending_loads: got %0d outstanding, expected 0", exp_q.size()); end
        checks++; if (loads_seen != loads_pushed) begin errors++; $display("FAIL load_count: got %0d, expected %0d", loads_seen, loads_pushed); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-setting controller that sequences the hours/minutes/seconds time-of-day counter.
- Freezes the counter while the user edits the time with mode/inc/dec buttons.
- Loads the edited time back into the counter on commit.
- Sits between the debounced front-panel buttons and the counter's enable/parallel-load port; runs on the fast system clock and uses a 1 Hz tick enable.

Parameters:
- REPEAT_DELAY, 50_000_000: Clk cycles an inc/dec button must stay held before auto-repeat starts.
- REPEAT_RATE, 10_000_000: Clk cycles between auto-repeat steps once repeat is active.
- TIMEOUT_TICKS, 30: tick_1hz pulses with no button activity before edit mode is abandoned.

Ports:
- Clk, input, 1: system clock; all logic on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- tick_1hz, input, 1: one-Clk-wide pulse, once per second.
- btn_mode, input, 1: mode button; synchronous, debounced, level, active-high.
- btn_inc, input, 1: increment button; same conditioning as btn_mode.
- btn_dec, input, 1: decrement button; same conditioning as btn_mode.
- cur_hours, input, 5: current counter hours (0-23).
- cur_minutes, input, 6: current counter minutes (0-59).
- cur_seconds, input, 6: current counter seconds (0-59).
- count_en, output, 1: counter advance enable.
- load_en, output, 1: one-cycle parallel-load strobe to the counter.
- load_hours, output, 5: edited hours value.
- load_minutes, output, 6: edited minutes value.
- load_seconds, output, 6: edited seconds value.
- mode, output, 2: current state encoding.
- blink, output, 1: display blink for the field being edited.

Behaviour:
- Reset (reset_n=0, async):
  - state=RUN, all edit registers=0, load_en=0, count_en=1, blink=0, mode=0.
  - Button history registers=0, repeat and timeout counters=0.
- States and encodings: RUN=0, SET_HOURS=1, SET_MINUTES=2, SET_SECONDS=3. mode = state, registered.
- count_en=1 only in RUN. It drops in the same cycle the state register leaves RUN.
- Edge detect: a button edge is btn=1 while its previous-cycle register=0. Edges are evaluated at Clk edge N; effects are visible after edge N.
- Mode-edge transitions:
  - RUN -> SET_HOURS: edit_h/m/s capture cur_hours/minutes/seconds.
  - SET_HOURS -> SET_MINUTES.
  - SET_MINUTES -> SET_SECONDS.
  - SET_SECONDS -> RUN: load_en=1 for exactly one cycle with load_* = edit registers. count_en=1 in that same cycle; the counter gives load priority over increment.
- Outside the commit cycle, load_* continuously reflect the edit registers and load_en=0.
- Inc/dec steps apply in set states only. A step changes the field selected by state:
  - Hours: inc 23->0 wraps; dec 0->23 wraps.
  - Minutes and seconds: inc 59->0 wraps; dec 0->59 wraps.
  - Arithmetic is done at field width plus compare-and-wrap. Edit values never exceed the legal range.
- A step is generated by:
  - the press edge, or
  - auto-repeat: held continuously for REPEAT_DELAY cycles gives one step, then one step every REPEAT_RATE cycles while held.
  - Release clears the repeat counter.
- Simultaneous events:
  - inc and dec both active in the same cycle: no step, repeat counter cleared.
  - Mode edge together with an inc/dec step: the mode transition wins and the step is discarded.
- Inc/dec in RUN are ignored.
- Timeout:
  - In set states, a 0..TIMEOUT_TICKS counter increments on tick_1hz.
  - Any button edge or repeat step clears it to 0.
  - On reaching TIMEOUT_TICKS: state -> RUN with no load_en. Edits are discarded and the counter resumes from its frozen value.
  - The timeout counter is cleared on entry to any set state.
- Blink:
  - blink=0 in RUN.
  - In set states it toggles on every tick_1hz and is forced to 1 for one second after any step, so the edited value stays visible.
- Reset mid-edit returns to RUN immediately; no load is issued.

Decomposition:
- Shared package clock_pkg:
  - state enum ctl_state_t {RUN, SET_HOURS, SET_MINUTES, SET_SECONDS}.
  - Constants HOURS_MAX=23, MIN_SEC_MAX=59.
  - Widths HOURS_W=5, MIN_SEC_W=6.
- One sub-module, btn_repeat: edge detect plus hold/auto-repeat counter, instantiated twice (inc, dec). Its output is a single-cycle step pulse.

Test Plan:
- Reset with cur=12:34:56 -> count_en=1, load_en=0, mode=0, blink=0, load_*=0.
- cur=12:34:56; one mode press -> mode=1, count_en=0, load_*=12:34:56. Then 12 inc presses -> load_hours=0 (wrap 23->0). Three more mode presses -> single load_en pulse with 00:34:56, count_en=1.
- In SET_MINUTES at 0, one dec press -> load_minutes=59. Hold inc for REPEAT_DELAY+3*REPEAT_RATE cycles (small bench params) -> exactly 4 steps, load_minutes=3.
- Enter SET_HOURS, no buttons, TIMEOUT_TICKS tick_1hz pulses -> mode=0, count_en=1, no load_en at any point.
- Mode and inc edges in the same cycle while in SET_HOURS -> mode=2, load_hours unchanged. inc+dec held together -> no step.
- reset_n pulsed low mid-SET_SECONDS -> mode=0 and count_en=1 asynchronously, load_en never asserted.
